// File: rtl/sa_autosa_rubik_wrdma_data.sv
// Write-DMA data staging FIFO: DEPTH-entry queue with registered valid/ready on both sides.
// Define RUBIK_WRDMA_FIFO_CHECK_EN to compile simulation checks for overflow, underflow and occupancy range.
module sa_autosa_rubik_wrdma_data #(
   parameter int WIDTH = 256,
   parameter int DEPTH = 4
) (
   input  logic             autosa_core_clk,
   input  logic             autosa_core_rst,
   input  logic             idata_pvld,
   output logic             idata_prdy,
   input  logic [WIDTH-1:0] idata_pd,
   output logic             odata_pvld,
   input  logic             odata_prdy,
   output logic [WIDTH-1:0] odata_pd,
   input  logic [31:0]      pwrbus_ram_pd
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    wr_ptr_next;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW-1:0]    rd_ptr_next;
   logic [CW-1:0]    count_reg;
   logic [CW-1:0]    count_next;
   logic             push;
   logic             pop;
   logic [DEPTH-1:0] wr_en;
   logic [WIDTH-1:0] mem_reg [DEPTH];

   // Power-down hints are not used by this register-based storage.
   logic unused_pwrbus;
   assign unused_pwrbus = ^pwrbus_ram_pd;

   // Handshake flags come only from the occupancy register, so neither side sees the other combinationally.
   assign idata_prdy = (count_reg < DEPTH_C);
   assign odata_pvld = (count_reg != '0);
   assign push       = idata_pvld & idata_prdy;
   assign pop        = odata_pvld & odata_prdy;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (push) begin
         wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (pop) begin
         rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
         count_next = count_reg + 1'b1;
      end else if (pop && !push) begin
         count_next = count_reg - 1'b1;
      end
   end

   always_ff @(posedge autosa_core_clk or posedge autosa_core_rst) begin
      if (autosa_core_rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_wr_en
         assign wr_en[gi] = push && (wr_ptr_reg == AW'(gi));
      end
   endgenerate

   // Storage is deliberately left out of reset; the cleared occupancy makes stale entries invisible.
   always_ff @(posedge autosa_core_clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_en[i]) begin
            mem_reg[i] <= idata_pd;
         end
      end
   end

   assign odata_pd = mem_reg[rd_ptr_reg];

`ifdef RUBIK_WRDMA_FIFO_CHECK_EN
   always @(posedge autosa_core_clk) begin
      if (!autosa_core_rst) begin
         if (push && (count_reg >= DEPTH_C)) begin
            $error("sa_autosa_rubik_wrdma_data: push while full");
         end
         if (pop && (count_reg == '0)) begin
            $error("sa_autosa_rubik_wrdma_data: pop while empty");
         end
         if (count_reg > DEPTH_C) begin
            $error("sa_autosa_rubik_wrdma_data: occupancy %0d exceeds depth", count_reg);
         end
      end
   end
`else
`endif

endmodule

// File: tb/tb_sa_autosa_rubik_wrdma_data.sv
// Randomised bench for sa_autosa_rubik_wrdma_data, checked cycle by cycle against a queue reference model.
module tb_sa_autosa_rubik_wrdma_data;

   localparam int W = 73;
   localparam int D = 4;

   logic          autosa_core_clk = 1'b0;
   logic          autosa_core_rst = 1'b1;
   logic          idata_pvld = 1'b0;
   logic          idata_prdy;
   logic [W-1:0]  idata_pd = '0;
   logic          odata_pvld;
   logic          odata_prdy = 1'b0;
   logic [W-1:0]  odata_pd;
   logic [31:0]   pwrbus_ram_pd = '0;

   int test_cnt = 0;
   int fail_cnt = 0;
   int cyc = 0;
   logic [W-1:0] model_q [$];

   sa_autosa_rubik_wrdma_data #(.WIDTH(W), .DEPTH(D)) dut (
      .autosa_core_clk (autosa_core_clk),
      .autosa_core_rst (autosa_core_rst),
      .idata_pvld      (idata_pvld),
      .idata_prdy      (idata_prdy),
      .idata_pd        (idata_pd),
      .odata_pvld      (odata_pvld),
      .odata_prdy      (odata_prdy),
      .odata_pd        (odata_pd),
      .pwrbus_ram_pd   (pwrbus_ram_pd)
   );

   always #5 autosa_core_clk = ~autosa_core_clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      test_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      return r[W-1:0];
   endfunction

   // One clock cycle: drive at the falling edge, compare against the model, then retire the cycle in the model.
   task automatic step(input logic pv, input logic [W-1:0] pd, input logic pr);
      bit do_push;
      bit do_pop;
      @(negedge autosa_core_clk);
      idata_pvld = pv;
      idata_pd   = pd;
      odata_prdy = pr;
      #1;
      check("odata_pvld", {127'd0, odata_pvld}, {127'd0, model_q.size() != 0});
      check("idata_prdy", {127'd0, idata_prdy}, {127'd0, model_q.size() < D});
      if (model_q.size() != 0) begin
         check("odata_pd", {55'd0, odata_pd}, {55'd0, model_q[0]});
      end
      do_push = pv && (model_q.size() < D);
      do_pop  = pr && (model_q.size() != 0);
      $display("[TB] cyc %0d push=%0b pop=%0b occ=%0d pd=%h", cyc, do_push, do_pop, model_q.size(), pd);
      @(posedge autosa_core_clk);
      cyc++;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(pd);
   endtask

   // Reset asserted between clock edges must clear the flags without waiting for a clock.
   task automatic mid_reset();
      @(negedge autosa_core_clk);
      idata_pvld = 1'b0;
      odata_prdy = 1'b0;
      #2;
      autosa_core_rst = 1'b1;
      #1;
      check("rst_pvld", {127'd0, odata_pvld}, 128'd0);
      check("rst_prdy", {127'd0, idata_prdy}, 128'd1);
      model_q.delete();
      $display("[TB] cyc %0d reset asserted", cyc);
      @(posedge autosa_core_clk);
      @(negedge autosa_core_clk);
      autosa_core_rst = 1'b0;
   endtask

   initial begin
      logic [W-1:0] v;
      #1;
      check("por_pvld", {127'd0, odata_pvld}, 128'd0);
      check("por_prdy", {127'd0, idata_prdy}, 128'd1);
      @(posedge autosa_core_clk);
      @(negedge autosa_core_clk);
      autosa_core_rst = 1'b0;

      // Single push: visible only on the following cycle.
      step(1'b1, W'(8'hA5), 1'b0);
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);

      // Fill, refused fifth push, then drain in order.
      for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b0);
      step(1'b1, W'(5), 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);

      // Full with simultaneous pop: no push that cycle, ready again next cycle.
      for (int i = 0; i < 4; i++) step(1'b1, W'(16 + i), 1'b0);
      step(1'b1, W'(32), 1'b1);
      step(1'b1, W'(33), 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

      // Streaming with both sides held ready.
      for (int i = 0; i < 20; i++) step(1'b1, W'(100 + i), 1'b1);
      step(1'b0, '0, 1'b1);

      // Reset with three entries held; first push afterwards must be the first value out.
      for (int i = 0; i < 3; i++) step(1'b1, W'(200 + i), 1'b0);
      mid_reset();
      step(1'b1, W'(300), 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);

      // Random back-pressure against the reference queue.
      for (int i = 0; i < 1000; i++) begin
         v = rand_word();
         step(($urandom_range(0, 3) != 0), v, ($urandom_range(0, 2) != 0));
      end
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/sa_autosa_rubik_wrdma_data.md
SA_AUTOSA_RUBIK_WRDMA_DATA -- requirements
Module: sa_autosa_rubik_wrdma_data

Interface
REQ-001 SHALL have parameter WIDTH, default 256, payload bit width; the command-queue instance uses 73.
REQ-002 SHALL have parameter DEPTH, default 4, entry count; power of two, minimum 2.
REQ-003 SHALL have port autosa_core_clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port autosa_core_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port idata_pvld  input  1  write-side valid.
REQ-006 SHALL have port idata_prdy  output  1  write-side ready.
REQ-007 SHALL have port idata_pd  input  WIDTH  write payload.
REQ-008 SHALL have port odata_pvld  output  1  read-side valid.
REQ-009 SHALL have port odata_prdy  input  1  read-side ready.
REQ-010 SHALL have port odata_pd  output  WIDTH  read payload, head entry.
REQ-011 SHALL have port pwrbus_ram_pd  input  32  RAM power-down control; accepted and functionally ignored.

Function
REQ-012 SHALL be a first-in first-out queue of DEPTH entries; push = idata_pvld & idata_prdy, pop = odata_pvld & odata_prdy.
REQ-013 SHALL drive idata_prdy = (occupancy < DEPTH), from registered state only; no combinational path from odata_prdy.
REQ-014 SHALL drive odata_pvld = (occupancy > 0), from registered state only; no combinational path from idata_pvld.
REQ-015 SHALL present a pushed entry on odata_pd/odata_pvld no earlier than the cycle after the push; no same-cycle fall-through.
REQ-016 SHALL hold odata_pd stable, equal to the head entry, while odata_pvld=1 and odata_prdy=0.
REQ-017 SHALL make odata_pd a don't-care while odata_pvld=0.
REQ-018 SHALL track occupancy in a counter of log2(DEPTH)+1 bits: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-019 SHALL use write and read pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-020 SHALL, when full with a simultaneous pop, deassert idata_prdy that cycle (no push) and reassert it the next cycle.
REQ-021 SHALL, when occupancy is 1 with a simultaneous push and pop, pop the old head and show the new entry with odata_pvld=1 the next cycle.
REQ-022 SHALL ignore idata_pd when there is no push and odata_prdy when there is no pop; no state change.
REQ-023 SHALL preserve data bit-exactly and in order, with no loss or duplication, for any handshake pattern.

Reset
REQ-024 SHALL, while autosa_core_rst=1, clear occupancy and both pointers, giving odata_pvld=0 and idata_prdy=1 immediately, asynchronously.
REQ-025 SHALL discard all stored entries on reset mid-operation; storage contents need not be reset.
REQ-026 SHALL resume normal operation on the first rising clock edge after reset deasserts.

Configuration
REQ-027 SHALL support macro RUBIK_WRDMA_FIFO_CHECK_EN: when defined, simulation checks flag an error on push while full, pop while empty, or occupancy > DEPTH.
REQ-028 SHALL, when RUBIK_WRDMA_FIFO_CHECK_EN is undefined, compile no checking logic, with identical port behaviour.

Verification
REQ-029 SHALL cover reset then idle: odata_pvld=0, idata_prdy=1; push 0xA5 at cycle 0 -> odata_pvld=1 and odata_pd=0xA5 at cycle 1, not cycle 0.
REQ-030 SHALL cover filling: push 1,2,3,4 with odata_prdy=0 -> idata_prdy=0 after the 4th push; a 5th push attempt is not accepted.
REQ-031 SHALL cover draining: from full, odata_prdy=1 for 4 cycles -> outputs 1,2,3,4 in order, then odata_pvld=0 and idata_prdy=1.
REQ-032 SHALL cover streaming: idata_pvld and odata_prdy both held at 1 for 20 values -> 20 values out in order; occupancy stays <= 1 after start.
REQ-033 SHALL cover back-pressure: random pvld/prdy over 1000 cycles against a reference queue -> exact order match; the wrap-around of both pointers is exercised.
REQ-034 SHALL cover reset mid-operation: with occupancy 3, assert reset -> odata_pvld=0 and idata_prdy=1 in the same cycle; the next push is the first value output.
